pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Parametrised successor to the two-bit next-PC select: owns the PC register, adds stall handling, N-way prioritised redirect sources, a pending-redirect buffer that carries a redirect across stall cycles, and a one-cycle flush pulse toward the fetch/decode pipeline registers. It sits at the front of the pipelined MCU, feeding PC_OUT to instruction memory and PC_PLUS_FOUR down the pipe.

## Interface
- XLEN, 32, PC and target width.
- NUM_SRC, 4, number of redirect sources; index 0 is highest priority (typical wiring: 0=trap/mret, 1=JALR, 2=BRANCH, 3=JAL).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, sequential increment.
- TRAP_VEC, 32'h0000_0000, misaligned-target redirect address (used only with the macro).
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- STALL  in  1  hold PC this cycle.
- REDIRECT_VALID  in  NUM_SRC  per-source redirect request.
- REDIRECT_TARGET  in  NUM_SRC*XLEN  packed targets; source i at bits [i*XLEN +: XLEN].
- PC_OUT  out  XLEN  current PC (registered).
- PC_PLUS_FOUR  out  XLEN  PC_OUT + PC_INC (combinational from register).
- FLUSH  out  1  one-cycle pulse: PC_OUT was just loaded from a redirect.
- PENDING  out  1  a redirect is buffered awaiting STALL release.
- MISALIGN  out  1  one-cycle pulse: a misaligned target was rejected.
- BAD_ADDR  out  XLEN  rejected target, valid while MISALIGN=1.

## Operation
- Live selection: lowest index i with REDIRECT_VALID[i]=1 gives sel_target; live_valid = |REDIRECT_VALID.
- States: RUN (no buffered redirect), HOLD (pending register valid).
- RUN, STALL=0: live_valid → PC ← sel_target, FLUSH next cycle; else PC ← PC+PC_INC.
- RUN, STALL=1: PC holds; live_valid → pend ← sel_target, go HOLD.
- HOLD, STALL=1: PC holds; live_valid → pend overwritten by sel_target (newest wins); stay HOLD.
- HOLD, STALL=0: live_valid → PC ← sel_target, else PC ← pend; FLUSH next cycle; go RUN.
- PENDING = (state==HOLD).
- Arithmetic: PC+PC_INC truncated to XLEN bits (wraps at 2^XLEN−PC_INC → 0).
- Reset (RST=1 at edge) overrides everything, including mid-stall or in HOLD: state RUN, pend cleared.

## Timing
- Reset values: PC_OUT=RESET_PC, PC_PLUS_FOUR=RESET_PC+PC_INC, FLUSH=0, PENDING=0, MISALIGN=0, BAD_ADDR=0.
- Redirect latency: 1 cycle (request at edge k, PC_OUT=target after edge k, FLUSH=1 during cycle k+1 only).
- FLUSH is registered; never asserted two consecutive cycles unless redirects are taken on consecutive non-stalled cycles.
- Simultaneous STALL=1 and redirect: PC unchanged, redirect buffered, no FLUSH until release.
- Redirect in the same cycle RST=1: ignored.

## Configuration
- PC_MISALIGN_CHK_EN defined: any target about to load PC (live or pending) with bits [1:0]≠0 is rejected; PC ← TRAP_VEC, MISALIGN=1 and BAD_ADDR=target next cycle, FLUSH=1 as well. Check applies at load time, not at buffering.
- Undefined: targets load unchecked; MISALIGN and BAD_ADDR tied 0; TRAP_VEC unused.

## Structure
- Package pc_next_pkg: typedef enum logic {PC_RUN, PC_HOLD} pc_state_t; localparam default PC_INC and RESET_PC.
- Sub-module pc_prio_sel: parametrised priority encoder/mux (NUM_SRC, XLEN) → sel_target, live_valid, sel_idx.
- Top holds PC register, pend register, state, FLUSH/MISALIGN registers.

## Test plan
- Reset then free run, no redirects: PC_OUT 0x0, 0x4, 0x8, 0xC on successive cycles; FLUSH=0 throughout.
- Sources 1 (0x100) and 3 (0x200) valid same cycle, STALL=0: PC_OUT=0x100 next cycle, FLUSH=1 one cycle, then 0x104.
- STALL=1 for 3 cycles with PC=0x40, redirect 0x300 on cycle 1, 0x380 on cycle 2: PC stays 0x40, PENDING=1 from cycle 2; on release PC=0x380, FLUSH=1, PENDING=0.
- HOLD with pend=0x300, release cycle also carries live redirect 0x500: PC=0x500, pend discarded.
- RST asserted while PENDING=1: next cycle PC_OUT=RESET_PC, PENDING=0, FLUSH=0; PC at 0xFFFF_FFFC increments to 0x0.
- With PC_MISALIGN_CHK_EN, redirect 0x102: PC=TRAP_VEC, MISALIGN=1, BAD_ADDR=0x102 for one cycle; without macro PC=0x102, MISALIGN=0.

Source files
------------

// File: rtl/pc_next_pkg.sv
// Shared types and defaults for the next-PC unit.
//   pc_state_t     : PC_RUN (no buffered redirect) / PC_HOLD (pending redirect valid)
//   DefaultPcInc   : default sequential increment
//   DefaultResetPc : default PC after reset
package pc_next_pkg;

  typedef enum logic {
    PC_RUN,
    PC_HOLD
  } pc_state_t;

  localparam int unsigned DefaultPcInc   = 4;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

endpackage

// File: rtl/pc_next_unit_if.sv
// Bus between the pipeline control and the next-PC unit.
//   stall           : hold PC this cycle
//   redirect_valid  : per-source redirect request, index 0 highest priority
//   redirect_target : packed targets, source i at [i*XLEN +: XLEN]
//   pc              : current PC (registered)
//   pc_plus_four    : pc + increment
//   flush           : one-cycle pulse, pc was just loaded from a redirect
//   pending         : a redirect is buffered awaiting stall release
//   misalign        : one-cycle pulse, a misaligned target was rejected
//   bad_addr        : rejected target, valid while misalign is high
// master = pipeline side, slave = next-PC unit.
interface pc_next_unit_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 4
);

  logic                      stall;
  logic [NUM_SRC-1:0]        redirect_valid;
  logic [NUM_SRC*XLEN-1:0]   redirect_target;
  logic [XLEN-1:0]           pc;
  logic [XLEN-1:0]           pc_plus_four;
  logic                      flush;
  logic                      pending;
  logic                      misalign;
  logic [XLEN-1:0]           bad_addr;

  modport master (
    output stall, redirect_valid, redirect_target,
    input  pc, pc_plus_four, flush, pending, misalign, bad_addr
  );

  modport slave (
    input  stall, redirect_valid, redirect_target,
    output pc, pc_plus_four, flush, pending, misalign, bad_addr
  );

endinterface

// File: rtl/pc_prio_sel.sv
// Priority selector for redirect sources: lowest index with a valid request wins.
//   valid_i      : per-source request
//   target_i     : packed targets, source i at [i*XLEN +: XLEN]
//   sel_target_o : target of the winning source (0 when none valid)
//   live_valid_o : any source valid
//   sel_idx_o    : index of the winning source (0 when none valid)
module pc_prio_sel #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned XLEN    = 32,
  localparam int unsigned IdxW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0]      valid_i,
  input  logic [NUM_SRC*XLEN-1:0] target_i,
  output logic [XLEN-1:0]         sel_target_o,
  output logic                    live_valid_o,
  output logic [IdxW-1:0]         sel_idx_o
);

  // Walk from the lowest priority upward so the lowest valid index is written last.
  always_comb begin
    sel_idx_o    = '0;
    sel_target_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        sel_idx_o    = IdxW'(i);
        sel_target_o = target_i[i*XLEN +: XLEN];
      end
    end
  end

  assign live_valid_o = |valid_i;

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC unit: owns the PC register, handles stalls, prioritised redirects,
// a pending-redirect buffer that carries a redirect across stall cycles, and
// a registered one-cycle flush pulse toward fetch/decode.
//   clk_i  : clock, all state updates on the rising edge
//   rst_i  : synchronous active-high reset
//   bus_io : pc_next_unit_if slave (stall/redirect in, pc/flush/pending/misalign out)
// Optional: define PC_MISALIGN_CHK_EN to reject targets with bits [1:0] != 0
// at load time (PC <- TRAP_VEC, misalign/bad_addr pulse). Without it,
// misalign and bad_addr stay 0 and TRAP_VEC has no effect.
module pc_next_unit
  import pc_next_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NUM_SRC  = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DefaultResetPc),
  parameter int unsigned     PC_INC   = DefaultPcInc,
  parameter logic [XLEN-1:0] TRAP_VEC = '0
) (
  input logic            clk_i,
  input logic            rst_i,
  pc_next_unit_if.slave  bus_io
);

  localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  pc_state_t       state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_q;
  logic            flush_q;
  logic            misalign_q;
  logic [XLEN-1:0] bad_addr_q;

  logic [XLEN-1:0] sel_target;
  logic            live_valid;
  logic [IdxW-1:0] sel_idx;

  logic            load_en;
  logic [XLEN-1:0] load_target;
  logic            load_bad;
  logic [XLEN-1:0] pc_plus_inc;

  pc_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .XLEN    (XLEN)
  ) u_prio_sel (
    .valid_i      (bus_io.redirect_valid),
    .target_i     (bus_io.redirect_target),
    .sel_target_o (sel_target),
    .live_valid_o (live_valid),
    .sel_idx_o    (sel_idx)
  );

  // Only the target matters here; the index is kept for debug visibility.
  logic unused_sel_idx;
  assign unused_sel_idx = ^sel_idx;

  assign pc_plus_inc = pc_q + XLEN'(PC_INC);

  // A redirect loads PC on any non-stalled cycle with a live request or a
  // buffered one; a live request on the release cycle beats the buffer.
  assign load_en     = !bus_io.stall && (live_valid || (state_q == PC_HOLD));
  assign load_target = live_valid ? sel_target : pend_q;

`ifdef PC_MISALIGN_CHK_EN
  assign load_bad = |load_target[1:0];
`else
  assign load_bad = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= PC_RUN;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      flush_q    <= load_en;
      misalign_q <= load_en && load_bad;
      bad_addr_q <= (load_en && load_bad) ? load_target : '0;

      case (state_q)
        PC_RUN: begin
          if (bus_io.stall) begin
            if (live_valid) begin
              pend_q  <= sel_target;
              state_q <= PC_HOLD;
            end
          end else if (!live_valid) begin
            pc_q <= pc_plus_inc;
          end
        end
        PC_HOLD: begin
          if (bus_io.stall) begin
            // Newest redirect wins while still stalled.
            if (live_valid) begin
              pend_q <= sel_target;
            end
          end else begin
            pend_q  <= '0;
            state_q <= PC_RUN;
          end
        end
      endcase

      if (load_en) begin
        pc_q <= load_bad ? TRAP_VEC : load_target;
      end
    end
  end

  assign bus_io.pc           = pc_q;
  assign bus_io.pc_plus_four = pc_plus_inc;
  assign bus_io.flush        = flush_q;
  assign bus_io.pending      = (state_q == PC_HOLD);
  assign bus_io.misalign     = misalign_q;
  assign bus_io.bad_addr     = bad_addr_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios followed by
// randomized stall/redirect/reset traffic, all compared against a cycle
// model that keeps the buffered redirect in a queue.
module tb_pc_next_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] TrapVec = 32'h0000_0F00;

  logic clk;
  logic rst;

  pc_next_unit_if #(.XLEN(32), .NUM_SRC(4)) bus ();

  pc_next_unit #(
    .XLEN     (32),
    .NUM_SRC  (4),
    .RESET_PC (ResetPc),
    .PC_INC   (4),
    .TRAP_VEC (TrapVec)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  logic        m_flush;
  logic        m_mis;
  logic [31:0] m_bad;

  logic [31:0] tgt[4];

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input logic s, input logic r, input logic [3:0] v);
    logic        live;
    logic [31:0] lt;
    logic [31:0] ld;
    bus.stall          = s;
    rst                = r;
    bus.redirect_valid = v;
    for (int i = 0; i < 4; i++) bus.redirect_target[i*32 +: 32] = tgt[i];
    @(posedge clk);
    live = 1'b0;
    lt   = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && !live) begin
        live = 1'b1;
        lt   = tgt[i];
      end
    end
    m_flush = 1'b0;
    m_mis   = 1'b0;
    m_bad   = '0;
    if (r) begin
      m_pc = ResetPc;
      m_pend.delete();
    end else if (s) begin
      if (live) begin
        m_pend.delete();
        m_pend.push_back(lt);
      end
    end else if (live || m_pend.size() != 0) begin
      ld = live ? lt : m_pend[0];
      m_pend.delete();
      m_flush = 1'b1;
      m_pc    = ld;
`ifdef PC_MISALIGN_CHK_EN
      if (ld % 4 != 0) begin
        m_pc  = TrapVec;
        m_mis = 1'b1;
        m_bad = ld;
      end
`endif
    end else begin
      m_pc = m_pc + 32'd4;
    end
    #1;
    check_eq("pc", bus.pc, m_pc);
    check_eq("pc_plus_four", bus.pc_plus_four, m_pc + 32'd4);
    check_eq("flush", 32'(bus.flush), 32'(m_flush));
    check_eq("pending", 32'(bus.pending), 32'(m_pend.size() != 0));
    check_eq("misalign", 32'(bus.misalign), 32'(m_mis));
    check_eq("bad_addr", bus.bad_addr, m_bad);
  endtask

  task automatic set_tgt(input logic [31:0] t0, input logic [31:0] t1,
                         input logic [31:0] t2, input logic [31:0] t3);
    tgt[0] = t0;
    tgt[1] = t1;
    tgt[2] = t2;
    tgt[3] = t3;
  endtask

  initial begin
    logic [31:0] r;
    logic        s;
    logic        rr;
    logic [3:0]  v;
    m_pc    = ResetPc;
    m_flush = 1'b0;
    m_mis   = 1'b0;
    m_bad   = '0;
    set_tgt('0, '0, '0, '0);

    // Reset, then free run 0x0 -> 0x4 -> 0x8 -> 0xC.
    step(1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b0000);
    check_eq("reset_pc_const", bus.pc, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0000);
    check_eq("free_run_c", bus.pc, 32'hC);

    // Sources 1 and 3 together: source 1 wins.
    set_tgt('0, 32'h100, '0, 32'h200);
    step(1'b0, 1'b0, 4'b1010);
    check_eq("prio_pc", bus.pc, 32'h100);
    step(1'b0, 1'b0, 4'b0000);
    check_eq("prio_next", bus.pc, 32'h104);

    // Get to 0x40, then stall 3 cycles with redirects on cycles 1 and 2.
    set_tgt(32'h40, '0, '0, '0);
    step(1'b0, 1'b0, 4'b0001);
    step(1'b1, 1'b0, 4'b0000);
    set_tgt('0, '0, 32'h300, '0);
    step(1'b1, 1'b0, 4'b0100);
    set_tgt('0, 32'h380, '0, '0);
    step(1'b1, 1'b0, 4'b0010);
    check_eq("stall_hold_pc", bus.pc, 32'h40);
    step(1'b0, 1'b0, 4'b0000);
    check_eq("release_pc", bus.pc, 32'h380);

    // Pending 0x300, release carries live 0x500.
    set_tgt('0, '0, '0, 32'h300);
    step(1'b1, 1'b0, 4'b1000);
    set_tgt('0, '0, 32'h500, '0);
    step(1'b0, 1'b0, 4'b0100);
    check_eq("live_beats_pend", bus.pc, 32'h500);

    // Reset while pending.
    set_tgt(32'h600, '0, '0, '0);
    step(1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b1, 4'b0001);
    step(1'b0, 1'b0, 4'b0000);

    // Wrap at the top of the address space.
    set_tgt('0, '0, '0, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 4'b1000);
    step(1'b0, 1'b0, 4'b0000);
    check_eq("wrap_pc", bus.pc, 32'h0);

    // Misaligned target.
    set_tgt(32'h102, '0, '0, '0);
    step(1'b0, 1'b0, 4'b0001);
    step(1'b0, 1'b0, 4'b0000);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        r = $urandom;
        if ($urandom_range(7) != 0) r[1:0] = 2'b00;
        tgt[i] = r;
      end
      s  = ($urandom_range(9) < 4);
      rr = ($urandom_range(49) == 0);
      for (int i = 0; i < 4; i++) v[i] = ($urandom_range(3) == 0);
      step(s, rr, v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
